// File: rtl/arbiter4_ctrl.sv
// arbiter4_ctrl: four-requester arbiter / grant controller for one shared
// downstream resource. Grants are held until the owner finishes, drops its
// request, or HOLD_MAX cycles expire; one dead GAP cycle follows every grant.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   undefined -> fixed search order 3,2,1,0 (index 3 highest)
//   defined   -> rotating order (last-1),(last-2),(last-3),last mod 4
//
// Parameters:
//   HOLD_MAX  max consecutive grant cycles per owner (2..255, default 8)
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   req[3:0] in   request lines, one per agent
//   done     in   owner completion, sampled only while granting
//   gnt[3:0] out  one-hot grant, zero when no owner
//   gnt_id   out  encoded owner index, 2'b00 when no owner
//   valid    out  high while a grant is active (== |gnt)
//   timeout  out  one-cycle pulse after a grant is revoked by HOLD_MAX

module arbiter4_ctrl #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t     state;
  logic [7:0] cnt;

  logic [1:0] win;
  logic       hit;
  logic [1:0] idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last;

  // Search starts just below the previous winner and wraps,
  // so the previous winner is tried last.
  always_comb begin
    win = 2'd0;
    hit = 1'b0;
    idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last - 2'(k);
      if (!hit && req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = 2'd0;
    hit = 1'b0;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = 2'(k);
      if (!hit && req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
`endif

  logic owner_req;
  logic at_lim;
  logic rel;

  assign owner_req = req[gnt_id];
  assign at_lim    = (cnt == HOLD_LIM);
  assign rel       = done | ~owner_req | at_lim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      gnt     <= 4'b0000;
      gnt_id  <= 2'b00;
      valid   <= 1'b0;
      timeout <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last    <= 2'd0;
`endif
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            gnt    <= 4'b0001 << win;
            gnt_id <= win;
            valid  <= 1'b1;
            cnt    <= 8'd1;
            state  <= GRANT;
`ifdef ARB_ROUND_ROBIN_EN
            last   <= win;
`endif
          end
        end
        GRANT: begin
          if (rel) begin
            gnt     <= 4'b0000;
            gnt_id  <= 2'b00;
            valid   <= 1'b0;
            cnt     <= 8'd0;
            // Only a pure hold-limit revoke is flagged.
            timeout <= at_lim & ~done & owner_req;
            state   <= GAP;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter4_ctrl.sv
// tb_arbiter4_ctrl: scoreboard bench for arbiter4_ctrl.
// Expected outputs are queued when inputs are driven, checked after the edge.

module tb_arbiter4_ctrl;

  localparam int HM = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       valid;
  logic       timeout;

  arbiter4_ctrl #(.HOLD_MAX(HM)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .valid   (valid),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic       t;
  } exp_t;

  exp_t q[$];
  int   ids[$];
  int   n_chk;
  int   n_fail;
  int   n_to;
  int   n_gc;

  int m_st;
  int m_own;
  int m_cnt;
  int m_last;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int lst);
    int o;
    for (int i = 0; i < 4; i++) begin
      o = RR ? (lst + 3 - i) % 4 : 3 - i;
      if (r[o]) return o;
    end
    return 0;
  endfunction

  task automatic model(output exp_t e);
    int  w;
    bit  rd, rr_, rh;
    e = '0;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_last = 0; m_own = 0;
      return;
    end
    case (m_st)
      0: begin
        if (req != 4'b0) begin
          w = pick(req, m_last);
          m_own = w;
          m_cnt = 1;
          m_st = 1;
          if (RR) m_last = w;
          e.g = 4'(1 << w);
          e.id = 2'(w);
          e.v = 1'b1;
        end
      end
      1: begin
        rd = done;
        rr_ = !req[m_own];
        rh = (m_cnt == HM);
        if (rd || rr_ || rh) begin
          e.t = rh && !rd && !rr_;
          m_st = 2;
        end else begin
          if (m_cnt < 255) m_cnt++;
          e.g = 4'(1 << m_own);
          e.id = 2'(m_own);
          e.v = 1'b1;
        end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    exp_t e;
    req = r;
    done = d;
    model(e);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("gnt", 32'(gnt), 32'(e.g));
    chk("gnt_id", 32'(gnt_id), 32'(e.id));
    chk("valid", 32'(valid), 32'(e.v));
    chk("timeout", 32'(timeout), 32'(e.t));
    if (valid) begin
      ids.push_back(int'(gnt_id));
      n_gc++;
    end
    if (timeout) n_to++;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; n_to = 0; n_gc = 0;
    m_st = 0; m_own = 0; m_cnt = 0; m_last = 0;
    rst = 1'b1;
    req = 4'b0;
    done = 1'b0;

    // reset held three cycles
    repeat (3) step(4'b0000, 1'b0);
    rst = 1'b0;
    step(4'b0000, 1'b0);

    // single requester, done on third grant cycle
    ids.delete();
    repeat (3) step(4'b0001, 1'b0);
    chk("single_len", 32'(ids.size()), 32'd3);
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    chk("single_regrant", 32'(valid), 32'd1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // everyone requesting, done each grant cycle
    ids.delete();
    repeat (15) step(4'b1111, 1'b1);
    chk("all_cnt", 32'(ids.size()), 32'd5);
    for (int i = 0; i < ids.size(); i++)
      chk("all_seq", 32'(ids[i]), RR ? 32'((3 - i + 8) % 4) : 32'd3);

    // agent 3 leaves the pool
    ids.delete();
    repeat (3) step(4'b0111, 1'b1);
    chk("drop3_cnt", 32'(ids.size()), 32'd1);
    if (ids.size() > 0) chk("drop3_id", 32'(ids[0]), 32'd2);

    // hold limit on agent 2
    n_to = 0; n_gc = 0;
    repeat (7) step(4'b0100, 1'b0);
    chk("to_pulses", 32'(n_to), 32'd1);
    chk("to_gcycles", 32'(n_gc), 32'd5);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // owner drop, no preemption, done ignored in IDLE
    ids.delete();
    step(4'b0010, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    chk("no_preempt", 32'(gnt), 32'b0010);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    chk("after_drop_id", 32'(gnt_id), 32'd3);
    step(4'b0000, 1'b1);
    repeat (3) step(4'b0000, 1'b1);

    // async reset in the middle of a grant
    step(4'b0001, 1'b0);
    chk("pre_rst_valid", 32'(valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_valid", 32'(valid), 32'd0);
    chk("async_id", 32'(gnt_id), 32'd0);
    m_st = 0; m_cnt = 0; m_last = 0; m_own = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 300; i++)
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
